aes_key_schedule_mem: RTL and testbench



---
 rtl/aes_key_schedule_mem_pkg.sv | 22 ++
 rtl/aes_ks_ram.sv | 43 ++++
 rtl/aes_key_schedule_mem.sv | 138 +++++++++++++
 tb/tb_aes_key_schedule_mem.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_schedule_mem_pkg.sv
// ------------------------------------------------------------------
// aes_key_schedule_mem_pkg : AES key-schedule store constants, state type
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package aes_key_schedule_mem_pkg;

  localparam int AES_NUM_ROUNDS      = 10;
  localparam int AES_BYTES_PER_ROUND = 16;
  localparam int AES_KS_DEPTH        = (AES_NUM_ROUNDS + 1) * AES_BYTES_PER_ROUND;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_READ  = 2'd3
  } ks_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_ks_ram.sv
// ------------------------------------------------------------------
// aes_ks_ram : single-port synchronous RAM with registered read port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_ks_ram
  import aes_key_schedule_mem_pkg::*;
#(
  parameter int DEPTH = AES_KS_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic       i_re,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rdata;

  // Storage itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= 8'd0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/aes_key_schedule_mem.sv
// ------------------------------------------------------------------
// aes_key_schedule_mem : captures 176 expanded key bytes, replays fwd/rev
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module aes_key_schedule_mem
  import aes_key_schedule_mem_pkg::*;
#(
  parameter int NUM_ROUNDS      = AES_NUM_ROUNDS,
  parameter int BYTES_PER_ROUND = AES_BYTES_PER_ROUND,
  parameter int DEPTH           = (NUM_ROUNDS + 1) * BYTES_PER_ROUND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_start,
  input  logic       i_wr_en,
  input  logic [7:0] i_key_byte_in,
  input  logic       i_rd_start,
  input  logic       i_decrypt,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic [3:0] o_rd_round,
  output logic       o_rd_last,
  output logic       o_key_ready,
  output logic       o_busy
);

  localparam logic [7:0] c_LAST_ADDR  = 8'(DEPTH - 1);
  localparam logic [3:0] c_LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] c_LAST_BYTE  = 4'(BYTES_PER_ROUND - 1);

  ks_state_e  r_state;
  logic [7:0] r_wr_cnt;
  logic [3:0] r_round;
  logic [3:0] r_byte;
  logic       r_decrypt;
  logic       r_key_ready;
  logic       r_rd_valid;
  logic       r_rd_last;
  logic [3:0] r_rd_round;

  logic       w_we;
  logic       w_rd_req;
  logic       w_final;
  logic [7:0] w_raddr;
  logic [7:0] w_addr;

  // wr_start outranks everything, so a read is never issued on its cycle.
  assign w_rd_req = (r_state == ST_READ) && i_rd_en && !i_wr_start;
  assign w_we     = i_wr_en && (i_wr_start || (r_state == ST_LOAD));
  assign w_final  = (r_byte == c_LAST_BYTE) &&
                    (r_round == (r_decrypt ? 4'd0 : c_LAST_ROUND));
  assign w_raddr  = {r_round, 4'b0000} + {4'b0000, r_byte};
  assign w_addr   = w_we ? (i_wr_start ? 8'd0 : r_wr_cnt) : w_raddr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wr_cnt    <= 8'd0;
      r_round     <= 4'd0;
      r_byte      <= 4'd0;
      r_decrypt   <= 1'b0;
      r_key_ready <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_round  <= 4'd0;
    end else begin
      r_rd_valid <= w_rd_req;
      r_rd_last  <= w_rd_req && w_final;
      if (w_rd_req) begin
        r_rd_round <= r_round;
      end

      if (i_wr_start) begin
        r_state     <= ST_LOAD;
        r_key_ready <= 1'b0;
        r_wr_cnt    <= i_wr_en ? 8'd1 : 8'd0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (i_wr_en) begin
              if (r_wr_cnt == c_LAST_ADDR) begin
                r_state     <= ST_READY;
                r_key_ready <= 1'b1;
                r_wr_cnt    <= 8'd0;
              end else begin
                r_wr_cnt <= r_wr_cnt + 8'd1;
              end
            end
          end
          ST_READY: begin
            if (i_rd_start) begin
              r_decrypt <= i_decrypt;
              r_round   <= i_decrypt ? c_LAST_ROUND : 4'd0;
              r_byte    <= 4'd0;
              r_state   <= ST_READ;
            end
          end
          ST_READ: begin
            if (i_rd_en) begin
              r_byte <= r_byte + 4'd1;
              if (w_final) begin
                r_state <= ST_READY;
              end else if (r_byte == c_LAST_BYTE) begin
                r_round <= r_decrypt ? (r_round - 4'd1) : (r_round + 4'd1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  aes_ks_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_rd_req),
    .i_addr  (w_addr),
    .i_wdata (i_key_byte_in),
    .o_rdata (o_rd_data)
  );

  assign o_rd_valid  = r_rd_valid;
  assign o_rd_last   = r_rd_last;
  assign o_rd_round  = r_rd_round;
  assign o_key_ready = r_key_ready;
  assign o_busy      = (r_state == ST_LOAD) || (r_state == ST_READ);

endmodule

`default_nettype wire

// File: tb/tb_aes_key_schedule_mem.sv
// ------------------------------------------------------------------
// tb_aes_key_schedule_mem : directed bench for the key-schedule store
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_aes_key_schedule_mem;

  logic       clk;
  logic       rst;
  logic       wr_start;
  logic       wr_en;
  logic [7:0] key_byte_in;
  logic       rd_start;
  logic       decrypt;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] rd_round;
  logic       rd_last;
  logic       key_ready;
  logic       busy;

  int n_tests;
  int n_fail;

  aes_key_schedule_mem dut (
    .clk           (clk),
    .rst           (rst),
    .i_wr_start    (wr_start),
    .i_wr_en       (wr_en),
    .i_key_byte_in (key_byte_in),
    .i_rd_start    (rd_start),
    .i_decrypt     (decrypt),
    .i_rd_en       (rd_en),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_rd_round    (rd_round),
    .o_rd_last     (rd_last),
    .o_key_ready   (key_ready),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat_a(input int i);
    return 8'(i);
  endfunction

  function automatic logic [7:0] pat_b(input int i);
    return 8'(i * 7 + 1);
  endfunction

  // Full capture: wr_en rides on the wr_start cycle, so byte 0 lands with it.
  task automatic load_all(input bit use_b);
    wr_start    = 1'b1;
    wr_en       = 1'b1;
    key_byte_in = use_b ? pat_b(0) : pat_a(0);
    tick();
    wr_start = 1'b0;
    for (int i = 1; i < 176; i++) begin
      check("load_busy", busy, 1);
      check("load_ready_low", key_ready, 0);
      key_byte_in = use_b ? pat_b(i) : pat_a(i);
      tick();
    end
    wr_en = 1'b0;
    check("load_key_ready", key_ready, 1);
    check("load_done_busy", busy, 0);
  endtask

  initial begin
    int k;
    int r;
    int b;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    wr_start    = 1'b0;
    wr_en       = 1'b0;
    key_byte_in = 8'd0;
    rd_start    = 1'b0;
    decrypt     = 1'b0;
    rd_en       = 1'b0;
    tick();
    tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_round", rd_round, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // rd_start / rd_en in IDLE are ignored
    rd_start = 1'b1;
    rd_en    = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    check("idle_rd_valid", rd_valid, 0);
    check("idle_busy", busy, 0);
    rd_en = 1'b0;
    tick();
    check("idle_rd_valid2", rd_valid, 0);

    load_all(1'b0);

    // Encrypt replay, rd_en held
    rd_start = 1'b1;
    decrypt  = 1'b0;
    tick();
    rd_start = 1'b0;
    check("enc_busy", busy, 1);
    check("enc_no_early_valid", rd_valid, 0);
    rd_en = 1'b1;
    for (int i = 0; i < 176; i++) begin
      tick();
      check("enc_valid", rd_valid, 1);
      check("enc_data", rd_data, pat_a(i));
      check("enc_round", rd_round, i / 16);
      check("enc_last", rd_last, (i == 175) ? 1 : 0);
    end
    rd_en = 1'b0;
    check("enc_end_busy", busy, 0);
    check("enc_end_key_ready", key_ready, 1);
    tick();
    check("enc_after_valid", rd_valid, 0);
    check("enc_after_last", rd_last, 0);

    // Decrypt replay
    rd_start = 1'b1;
    decrypt  = 1'b1;
    tick();
    rd_start = 1'b0;
    decrypt  = 1'b0;
    rd_en    = 1'b1;
    for (int i = 0; i < 176; i++) begin
      r = 10 - i / 16;
      b = i % 16;
      k = r * 16 + b;
      tick();
      check("dec_valid", rd_valid, 1);
      check("dec_data", rd_data, pat_a(k));
      check("dec_round", rd_round, r);
      check("dec_last", rd_last, (i == 175) ? 1 : 0);
    end
    rd_en = 1'b0;
    check("dec_end_busy", busy, 0);
    tick();
    check("dec_after_valid", rd_valid, 0);

    // Gapped encrypt replay
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    for (int i = 0; i < 176; i++) begin
      rd_en = 1'b1;
      tick();
      check("gap_valid", rd_valid, 1);
      check("gap_data", rd_data, pat_a(i));
      check("gap_last", rd_last, (i == 175) ? 1 : 0);
      rd_en = 1'b0;
      tick();
      check("gap_idle_valid", rd_valid, 0);
    end
    check("gap_end_busy", busy, 0);

    // Simultaneous wr_start and rd_start in READY
    wr_start = 1'b1;
    rd_start = 1'b1;
    tick();
    wr_start = 1'b0;
    rd_start = 1'b0;
    check("both_busy", busy, 1);
    check("both_key_ready", key_ready, 0);
    rd_en = 1'b1;
    tick();
    tick();
    check("both_no_read", rd_valid, 0);
    rd_en = 1'b0;

    // Reset after 50 writes, then full reload and replay
    wr_start    = 1'b1;
    wr_en       = 1'b1;
    key_byte_in = 8'hEE;
    tick();
    wr_start = 1'b0;
    for (int i = 1; i < 50; i++) begin
      key_byte_in = 8'hEE;
      tick();
    end
    wr_en = 1'b0;
    rst   = 1'b0;
    tick();
    check("midrst_key_ready", key_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_data", rd_data, 0);
    rst = 1'b1;
    tick();
    load_all(1'b1);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_en    = 1'b1;
    for (int i = 0; i < 176; i++) begin
      tick();
      check("reload_data", rd_data, pat_b(i));
      check("reload_valid", rd_valid, 1);
    end
    rd_en = 1'b0;
    tick();

    // wr_start mid-READ: in-flight byte still returned, then LOAD
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_en    = 1'b1;
    tick();
    check("abort_b0", rd_data, pat_b(0));
    tick();
    check("abort_inflight_valid", rd_valid, 1);
    check("abort_inflight_data", rd_data, pat_b(1));
    check("abort_inflight_last", rd_last, 0);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    check("abort_no_valid", rd_valid, 0);
    check("abort_key_ready", key_ready, 0);
    check("abort_busy", busy, 1);
    tick();
    check("abort_busy2", busy, 1);
    check("abort_no_valid2", rd_valid, 0);
    rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
